hack_run_controller: RTL and testbench
======================================

Name: hack_run_controller

Overview:
- Sequencer for the Hack `Computer` block.
- Streams a program image into instruction ROM through a valid/ready port, then holds the CPU in reset for a fixed count and releases it.
- While the program runs, counts cycles and detects the canonical end-of-program spin loop (`(END) @END; 0;JMP`).
- Stops the run on halt, cycle-budget timeout or host command. Replaces fixed-delay `$stop` benches and drives the board-level top.

Parameters:
- ADDR_W, 15, ROM/PC address width
- DATA_W, 16, instruction word width
- RESET_CYCLES, 4, cycles cpu_reset is held before a run (>=1)
- HALT_REPEAT, 8, consecutive loop-match cycles that declare halt (>=1)
- MAX_CYCLES, 100_000_000, run-cycle budget before timeout (32-bit)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_load  in  1  pulse: begin program load
- cmd_run  in  1  pulse: reset CPU and run
- cmd_stop  in  1  pulse: abort run
- load_valid  in  1  load word valid
- load_ready  out  1  controller accepts word
- load_data  in  DATA_W  instruction word
- load_last  in  1  final word of image
- rom_we  out  1  ROM write strobe
- rom_addr  out  ADDR_W  ROM write address
- rom_wdata  out  DATA_W  ROM write data
- cpu_reset  out  1  drives Computer.reset
- debug_pc  in  ADDR_W  Computer.debug_pc
- busy  out  1  state is not IDLE/HALTED/TIMEOUT
- halted  out  1  sticky; halt detected
- timed_out  out  1  sticky; budget exhausted
- halt_pc  out  ADDR_W  pc latched at halt
- cycle_count  out  32  RUN cycles of the current/last run

Behaviour:
- States: IDLE, LOAD, RST, RUN, HALTED, TIMEOUT.
- Reset:
  - State goes to IDLE, cpu_reset=1.
  - All other outputs are 0, including rom_addr and cycle_count.
  - A reset asserted mid-LOAD or mid-RUN aborts immediately, with the same values.
- cpu_reset:
  - 0 only in RUN, 1 in every other state.
  - The CPU therefore never executes during a ROM write.
- Command priority in IDLE/HALTED/TIMEOUT: cmd_load > cmd_run. cmd_stop is ignored in these states.
- cmd_load:
  - Goes to LOAD.
  - Clears rom_addr, halted, timed_out.
- LOAD:
  - load_ready=1.
  - A word transfers when load_valid&load_ready. On that same cycle: rom_we=1, rom_wdata=load_data, rom_addr=current address, all combinational from the registered address.
  - Address increments after each transfer.
  - Transfer with load_last=1, or at address 2^ADDR_W-1, goes to IDLE next cycle. The address does not wrap.
  - load_valid low: no write, address held.
  - Commands are ignored in LOAD.
- cmd_run:
  - Goes to RST.
  - Clears cycle_count, halted, timed_out, halt detector.
- RST: hold for exactly RESET_CYCLES cycles, then go to RUN.
- RUN:
  - cycle_count increments each cycle.
  - cycle_count == MAX_CYCLES-1 on a RUN cycle: go to TIMEOUT, timed_out=1, count ends at MAX_CYCLES.
  - cmd_stop: go to IDLE, flags untouched.
  - Same-cycle priority: cmd_stop > halt > timeout.
- Halt detection (RUN only):
  - Registers pc_d1, pc_d2 plus a 2-bit sample-valid count.
  - match = samples>=2 && debug_pc==pc_d2.
  - Repeat counter increments on match and clears on no match.
  - match with repeat==HALT_REPEAT-1: go to HALTED, halted=1, halt_pc=debug_pc.
  - 1-cycle self-loops also satisfy the match.
  - Known limitation: any 2-instruction poll loop is reported as a halt.
- HALTED/TIMEOUT: flags and halt_pc hold until the next cmd_load/cmd_run.
- cmd_run from HALTED re-runs the same ROM image.

Decomposition:
- Package `hack_ctrl_pkg` holds:
  - the state_t enum
  - ADDR_W/DATA_W defaults
  - the 32-bit count type
- Sub-module `hack_halt_detector`:
  - Inputs: clk, reset, clear, enable, pc.
  - Outputs: halt, halt_pc.
  - Contains the pc delay line and repeat counter.

Test Plan:
- Load 3 words (0x0005, 0xEC10, 0x0000, load_last on 3rd) with load_valid gaps. Required: exactly 3 rom_we pulses at addr 0,1,2 with matching data; return to IDLE; cpu_reset=1 throughout.
- After that load, cmd_run. Required: cpu_reset=1 for 4 cycles, then 0. A program ending `@2; 0;JMP` at pc 2/3 gives halted=1, halt_pc in {2,3}, busy=0, cpu_reset=1.
- Run with MAX_CYCLES=20 on a straight-line 32-word program. Required: timed_out=1, cycle_count=20, halted=0.
- cmd_stop at RUN cycle 5. Required: IDLE next cycle, cycle_count=5, halted=0, timed_out=0.
- cmd_load and cmd_run in the same cycle from IDLE. Required: enters LOAD. Reset asserted at address 1 of a load, then released. Required: IDLE, rom_addr=0, rom_we=0.
- Load 2^ADDR_W words without load_last. Required: last write at 0x7FFF, then IDLE, with no wrap to 0.

Source files
------------

// File: rtl/hack_ctrl_pkg.sv
// Shared types and defaults for the Hack run controller and its helpers.
package hack_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 15;
    localparam int unsigned DEF_DATA_W = 16;

    typedef logic [31:0] count_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RST,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } state_t;

endpackage

// File: rtl/hack_halt_detector.sv
// Detects the end-of-program spin loop: pc repeating with period 1 or 2
// for HALT_REPEAT consecutive enabled cycles.
module hack_halt_detector
    import hack_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned HALT_REPEAT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [ADDR_W-1:0] pc,
    output logic              halt,
    output logic [ADDR_W-1:0] halt_pc
);

    localparam int unsigned REP_W = $clog2(HALT_REPEAT + 1);

    logic [ADDR_W-1:0] pc_d1;
    logic [ADDR_W-1:0] pc_d2;
    logic [1:0]        samples;
    logic [REP_W-1:0]  rep;
    logic              match;

    // Comparing against pc two cycles back also catches 1-cycle self-loops.
    always_comb begin
        match = (samples >= 2'd2) && (pc == pc_d2);
        halt  = enable && match && (rep == REP_W'(HALT_REPEAT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pc_d1   <= '0;
            pc_d2   <= '0;
            samples <= '0;
            rep     <= '0;
            halt_pc <= '0;
        end else if (enable) begin
            pc_d1 <= pc;
            pc_d2 <= pc_d1;
            if (samples != 2'd2) begin
                samples <= samples + 2'd1;
            end
            rep <= match ? rep + 1'b1 : '0;
            if (halt) begin
                halt_pc <= pc;
            end
        end
    end

endmodule

// File: rtl/hack_run_controller.sv
// Loads a program image into the Hack instruction ROM, then resets and runs
// the CPU until halt, cycle-budget timeout or a host stop command.
module hack_run_controller
    import hack_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned HALT_REPEAT  = 8,
    parameter count_t      MAX_CYCLES   = 32'd100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_load,
    input  logic              cmd_run,
    input  logic              cmd_stop,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] debug_pc,
    output logic              busy,
    output logic              halted,
    output logic              timed_out,
    output logic [ADDR_W-1:0] halt_pc,
    output logic [31:0]       cycle_count
);

    localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    count_t            cyc_q;
    logic              halted_q;
    logic              timed_q;
    logic [RST_W-1:0]  rst_cnt;

    logic in_cmd_state;
    logic accept_load;
    logic accept_run;
    logic xfer;
    logic at_budget;
    logic det_enable;
    logic det_clear;
    logic det_halt;

    always_comb begin
        in_cmd_state = (state == ST_IDLE) || (state == ST_HALTED) || (state == ST_TIMEOUT);
        accept_load  = in_cmd_state && cmd_load;
        accept_run   = in_cmd_state && !cmd_load && cmd_run;
        xfer         = (state == ST_LOAD) && load_valid;
        at_budget    = (cyc_q == MAX_CYCLES - 32'd1);
        det_enable   = (state == ST_RUN) && !cmd_stop;
        det_clear    = accept_load || accept_run;
    end

    hack_halt_detector #(
        .ADDR_W      (ADDR_W),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt (
        .clk     (clk),
        .reset   (reset),
        .clear   (det_clear),
        .enable  (det_enable),
        .pc      (debug_pc),
        .halt    (det_halt),
        .halt_pc (halt_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                if (accept_load) begin
                    state_nx = ST_LOAD;
                end else if (accept_run) begin
                    state_nx = ST_RST;
                end
            end
            ST_LOAD: begin
                // The top address ends the load rather than wrapping onto word 0.
                if (xfer && (load_last || addr_q == '1)) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RST: begin
                if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cmd_stop) begin
                    state_nx = ST_IDLE;
                end else if (det_halt) begin
                    state_nx = ST_HALTED;
                end else if (at_budget) begin
                    state_nx = ST_TIMEOUT;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            cyc_q    <= '0;
            halted_q <= 1'b0;
            timed_q  <= 1'b0;
            rst_cnt  <= '0;
        end else begin
            if (accept_load) begin
                addr_q   <= '0;
                halted_q <= 1'b0;
                timed_q  <= 1'b0;
            end
            if (accept_run) begin
                cyc_q    <= '0;
                halted_q <= 1'b0;
                timed_q  <= 1'b0;
                rst_cnt  <= '0;
            end
            if (xfer && addr_q != '1) begin
                addr_q <= addr_q + 1'b1;
            end
            if (state == ST_RST) begin
                rst_cnt <= rst_cnt + 1'b1;
            end
            if (state == ST_RUN) begin
                cyc_q <= cyc_q + 32'd1;
                if (state_nx == ST_HALTED) begin
                    halted_q <= 1'b1;
                end
                if (state_nx == ST_TIMEOUT) begin
                    timed_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        load_ready  = (state == ST_LOAD);
        rom_we      = xfer;
        rom_addr    = addr_q;
        rom_wdata   = xfer ? load_data : '0;
        cpu_reset   = (state != ST_RUN);
        busy        = (state == ST_LOAD) || (state == ST_RST) || (state == ST_RUN);
        halted      = halted_q;
        timed_out   = timed_q;
        cycle_count = cyc_q;
    end

endmodule

// File: tb/tb_hack_run_controller.sv
// Randomized bench for hack_run_controller against a trace-level reference of
// load addressing, reset timing and halt/timeout/stop outcomes.
module tb_hack_run_controller;

    localparam int AW    = 15;
    localparam int DW    = 16;
    localparam int RSTC  = 4;
    localparam int HREP  = 8;
    localparam int MAXC  = 20;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_load;
    logic          cmd_run;
    logic          cmd_stop;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_wdata;
    logic          cpu_reset;
    logic [AW-1:0] debug_pc;
    logic          busy;
    logic          halted;
    logic          timed_out;
    logic [AW-1:0] halt_pc;
    logic [31:0]   cycle_count;

    logic [DW-1:0] img [DEPTH];
    int            trace [64];

    int n_checks = 0;
    int n_pass   = 0;

    hack_run_controller #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .RESET_CYCLES (RSTC),
        .HALT_REPEAT  (HREP),
        .MAX_CYCLES   (32'(MAXC))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_load    (cmd_load),
        .cmd_run     (cmd_run),
        .cmd_stop    (cmd_stop),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .rom_we      (rom_we),
        .rom_addr    (rom_addr),
        .rom_wdata   (rom_wdata),
        .cpu_reset   (cpu_reset),
        .debug_pc    (debug_pc),
        .busy        (busy),
        .halted      (halted),
        .timed_out   (timed_out),
        .halt_pc     (halt_pc),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_image(input int n, input bit use_last, input int gap_pct);
        int i;
        int budget;
        i = 0;
        budget = n * 4 + 100;
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        check_eq("load_enter", 32'(load_ready), 32'd1);
        check_eq("load_clr_halted", 32'(halted), 32'd0);
        check_eq("load_clr_timeout", 32'(timed_out), 32'd0);
        while (i < n && budget > 0) begin
            budget--;
            load_valid = ($urandom_range(99) >= 32'(gap_pct));
            load_data  = img[i];
            load_last  = use_last && (i == n - 1);
            #1;
            check_eq("load_we", 32'(rom_we), 32'(load_valid));
            check_eq("load_cpu_reset", 32'(cpu_reset), 32'd1);
            if (load_valid) begin
                check_eq("load_addr", 32'(rom_addr), 32'(i));
                check_eq("load_wdata", 32'(rom_wdata), 32'(img[i]));
            end
            @(negedge clk);
            if (load_valid) i++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check_eq("load_count", 32'(i), 32'(n));
        check_eq("load_done_ready", 32'(load_ready), 32'd0);
        check_eq("load_done_busy", 32'(busy), 32'd0);
    endtask

    // Trace shapes: 0 straight line, 1 self-loop at n, 2 two-cycle loop at n, 3 three-cycle loop at n.
    task automatic make_trace(input int kind, input int n);
        for (int k = 0; k < 64; k++) begin
            if (kind == 0 || k < n) trace[k] = k;
            else if (kind == 1) trace[k] = n;
            else if (kind == 2) trace[k] = n + (k - n) % 2;
            else trace[k] = n + (k - n) % 3;
        end
    endtask

    task automatic run_prog(input int stop_at);
        int exp_k;
        int exp_kind;
        int exp_pc;
        int streak;
        int k;
        bit done;
        exp_k = 0; exp_kind = 2; exp_pc = 0; streak = 0;
        // Reference: outcome decided on the first run cycle that stops, halts or hits the budget.
        for (int c = 0; c < 64; c++) begin
            if (c == stop_at) begin exp_k = c; exp_kind = 0; break; end
            if (c >= 2 && trace[c] == trace[c-2]) streak++;
            else streak = 0;
            if (streak >= HREP) begin exp_k = c; exp_kind = 1; exp_pc = trace[c]; break; end
            if (c + 1 == MAXC) begin exp_k = c; exp_kind = 2; break; end
        end

        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        check_eq("run_clr_halted", 32'(halted), 32'd0);
        check_eq("run_clr_timeout", 32'(timed_out), 32'd0);
        check_eq("run_clr_count", cycle_count, 32'd0);
        check_eq("run_busy", 32'(busy), 32'd1);
        for (int i = 0; i < RSTC; i++) begin
            check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd1);
            @(negedge clk);
        end
        k = 0;
        done = 1'b0;
        while (!done && k < MAXC + 8) begin
            check_eq("run_cpu_reset", 32'(cpu_reset), 32'd0);
            debug_pc = AW'(trace[k]);
            cmd_stop = (k == stop_at);
            @(negedge clk);
            cmd_stop = 1'b0;
            k++;
            if (cpu_reset) done = 1'b1;
        end
        check_eq("run_length", 32'(k), 32'(exp_k + 1));
        check_eq("end_count", cycle_count, 32'(exp_k + 1));
        check_eq("end_halted", 32'(halted), 32'(exp_kind == 1));
        check_eq("end_timeout", 32'(timed_out), 32'(exp_kind == 2));
        check_eq("end_busy", 32'(busy), 32'd0);
        if (exp_kind == 1) check_eq("end_halt_pc", 32'(halt_pc), 32'(exp_pc));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] pc_keep;
        reset = 1'b1;
        cmd_load = 1'b0; cmd_run = 1'b0; cmd_stop = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0; debug_pc = '0;
        for (int i = 0; i < DEPTH; i++) img[i] = DW'($urandom);
        repeat (3) @(negedge clk);
        check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_addr", 32'(rom_addr), 32'd0);
        check_eq("rst_count", cycle_count, 32'd0);
        check_eq("rst_flags", {30'd0, halted, timed_out}, 32'd0);
        check_eq("rst_halt_pc", 32'(halt_pc), 32'd0);
        check_eq("rst_ready_we", {30'd0, load_ready, rom_we}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        img[0] = 16'h0005; img[1] = 16'hEC10; img[2] = 16'h0000;
        load_image(3, 1'b1, 40);

        make_trace(2, 2);
        run_prog(-1);
        pc_keep = halt_pc;
        for (int i = 0; i < 3; i++) begin
            cmd_stop = (i == 1);
            @(negedge clk);
            cmd_stop = 1'b0;
            check_eq("hold_halted", 32'(halted), 32'd1);
            check_eq("hold_halt_pc", 32'(halt_pc), 32'(pc_keep));
            check_eq("hold_cpu_reset", 32'(cpu_reset), 32'd1);
        end

        for (int i = 0; i < 32; i++) img[i] = DW'($urandom);
        load_image(32, 1'b1, 20);
        make_trace(0, 0);
        run_prog(-1);
        run_prog(4);

        cmd_load = 1'b1; cmd_run = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0; cmd_run = 1'b0;
        check_eq("both_cmd_load", 32'(load_ready), 32'd1);
        check_eq("both_cmd_cpu_reset", 32'(cpu_reset), 32'd1);
        load_valid = 1'b1; load_data = 16'h1234;
        @(negedge clk);
        check_eq("abort_pre_addr", 32'(rom_addr), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_addr", 32'(rom_addr), 32'd0);
        check_eq("abort_we", 32'(rom_we), 32'd0);
        check_eq("abort_ready", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 14; r++) begin
            int stop_at;
            make_trace($urandom_range(3), $urandom_range(14));
            stop_at = ($urandom_range(3) == 0) ? $urandom_range(MAXC - 1) : -1;
            run_prog(stop_at);
        end

        make_trace(0, 0);
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        for (int i = 0; i < RSTC + 3; i++) begin
            debug_pc = AW'(i);
            @(negedge clk);
        end
        check_eq("midrun_cpu_reset", 32'(cpu_reset), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrun_abort_count", cycle_count, 32'd0);
        check_eq("midrun_abort_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("midrun_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);

        load_image(DEPTH, 1'b0, 10);
        load_valid = 1'b1;
        #1;
        check_eq("full_no_wrap_addr", 32'(rom_addr), 32'(DEPTH - 1));
        check_eq("full_no_extra_we", 32'(rom_we), 32'd0);
        load_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
